// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-domain consumer of the async byte FIFO. Pops bytes while
// there is room, packs them little-endian into PACK-lane words and hands the
// words downstream over valid/ready. Partial words leave on flush or idle timeout.
module fifo_rd_packer #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned PACK          = 4,
    parameter int unsigned FLUSH_TIMEOUT = 64
) (
    input  logic                         rd_clk,
    input  logic                         rd_rst,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    input  logic                         flush,
    output logic [PACK*DATA_WIDTH-1:0]   out_data,
    output logic [PACK-1:0]              out_keep,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  word_count
);

    localparam int unsigned WORD_W = PACK * DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(PACK + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned IDLE_W = $clog2(FLUSH_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   acc_q,        acc_d;
    logic [CNT_W-1:0]    acc_cnt_q,    acc_cnt_d;
    logic                pop_q;
    logic [IDLE_W-1:0]   idle_q,       idle_d;
    logic [WORD_W-1:0]   out_data_q,   out_data_d;
    logic [PACK-1:0]     out_keep_q,   out_keep_d;
    logic                out_valid_q,  out_valid_d;
    logic [15:0]         word_count_q, word_count_d;

    logic can_load;
    logic land;
    logic full_xfer;
    logic part_xfer;
    logic xfer;
    logic timeout;
    logic flush_req;

    // Transfer and event qualifiers shared by the datapath and the FSM
    assign can_load  = !out_valid_q || out_ready;
    assign land      = pop_q;
    assign full_xfer = (acc_cnt_q == CNT_W'(PACK)) && can_load;
    assign part_xfer = (state_q == ST_FLUSH) && !pop_q && (acc_cnt_q != '0)
                       && (acc_cnt_q != CNT_W'(PACK)) && can_load;
    assign xfer      = full_xfer || part_xfer;
    assign timeout   = (idle_q == IDLE_W'(FLUSH_TIMEOUT));
    assign flush_req = flush || timeout;

    // Pop only when the accumulator plus the byte in flight still leaves a free lane;
    // this must see the live empty flag, so it is not registered.
    assign fifo_rd_en = !rd_rst && !fifo_empty && (state_q != ST_FLUSH)
                        && ((SUM_W'(acc_cnt_q) + SUM_W'(pop_q)) < SUM_W'(PACK));

    assign out_data   = out_data_q;
    assign out_keep   = out_keep_q;
    assign out_valid  = out_valid_q;
    assign word_count = word_count_q;

    // Next-state datapath: lane write, word transfer, handshake and idle timer
    always_comb begin
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        idle_d       = idle_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_valid_d  = out_valid_q;
        word_count_d = word_count_q;

        // A landing never coincides with a transfer: pops stop before the last lane fills.
        if (land) begin
            for (int i = 0; i < int'(PACK); i++) begin
                if (acc_cnt_q == CNT_W'(i)) begin
                    acc_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
                end
            end
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end

        if (xfer) begin
            acc_cnt_d   = '0;
            out_valid_d = 1'b1;
            for (int i = 0; i < int'(PACK); i++) begin
                if (CNT_W'(i) < acc_cnt_q) begin
                    out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i*DATA_WIDTH +: DATA_WIDTH];
                    out_keep_d[i]                          = 1'b1;
                end else begin
                    out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                    out_keep_d[i]                          = 1'b0;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready) begin
            word_count_d = word_count_q + 16'd1;
        end

        if (land || xfer || (state_q != ST_FILL)) begin
            idle_d = '0;
        end else if (fifo_empty && !timeout) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    // Datapath registers; reset discards the accumulator, in-flight byte and output word
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            pop_q        <= 1'b0;
            idle_q       <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_valid_q  <= 1'b0;
            word_count_q <= '0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            pop_q        <= fifo_rd_en;
            idle_q       <= idle_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_valid_q  <= out_valid_d;
            word_count_q <= word_count_d;
        end
    end

    // Control FSM: fill, emit full words, and drain partial words on request
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_q <= ST_FLUSH;
                    end else if (land) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (flush_req) begin
                        state_q <= ST_FLUSH;
                    end else if (full_xfer) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (part_xfer || ((acc_cnt_q == '0) && !pop_q)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: drives a behavioural FIFO into fifo_rd_packer and checks
// the packed words against byte streams grouped in software.
module tb_fifo_rd_packer;

    localparam int unsigned DW   = 8;
    localparam int unsigned PACK = 4;
    localparam int unsigned TO   = 64;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_count;

    fifo_rd_packer #(
        .DATA_WIDTH   (DW),
        .PACK         (PACK),
        .FLUSH_TIMEOUT(TO)
    ) dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_data (fifo_data),
        .flush     (flush),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_count(word_count)
    );

    always #5 rd_clk = ~rd_clk;

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          viol      = 0;
    int          stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic        rd_seen;
    logic        ov_seen;
    logic [15:0] exp_wc;

    logic [7:0]  fq[$];
    logic [31:0] got_d[$];
    logic [3:0]  got_k[$];
    int          hs_cyc[$];

    // Little-endian word built from four stream bytes
    function automatic logic [31:0] pack4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    // One clock: present FIFO state, monitor outputs, model the FIFO pop, advance
    task automatic cycle();
        logic       popped;
        logic [7:0] v;
        fifo_empty = (fq.size() == 0);
        #1;
        rd_seen = fifo_rd_en;
        ov_seen = out_valid;
        if (fifo_rd_en && fifo_empty) viol++;
        if (prev_stall && (!out_valid || out_data !== prev_data || out_keep !== prev_keep))
            stall_err++;
        prev_stall = out_valid && !out_ready && !rd_rst;
        prev_data  = out_data;
        prev_keep  = out_keep;
        popped = 1'b0;
        v      = 8'h00;
        if (out_valid && out_ready && !rd_rst) begin
            got_d.push_back(out_data);
            got_k.push_back(out_keep);
            hs_cyc.push_back(cyc);
            exp_wc = exp_wc + 16'd1;
        end
        if (fifo_rd_en && !fifo_empty) begin
            v      = fq.pop_front();
            popped = 1'b1;
        end
        @(posedge rd_clk);
        #1;
        if (popped) fifo_data = v;
        cyc++;
        @(negedge rd_clk);
    endtask

    task automatic clear_mon();
        got_d.delete();
        got_k.delete();
        hs_cyc.delete();
        exp_wc     = 16'd0;
        prev_stall = 1'b0;
        viol       = 0;
        stall_err  = 0;
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        flush  = 1'b0;
        cycle();
        cycle();
        rd_rst = 1'b0;
        clear_mon();
    endtask

    task automatic wait_words(input int n, input int budget, output logic ok);
        int k = 0;
        while (got_d.size() < n && k < budget) begin
            cycle();
            k++;
        end
        ok = (got_d.size() >= n);
    endtask

    task automatic test_reset();
        rd_rst = 1'b1; out_ready = 1'b0; flush = 1'b0;
        cycle(); cycle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_keep !== 4'h0) begin failures++; $display("FAIL reset_keep got=%h exp=0", out_keep); end
        checks++; if (word_count !== 16'h0) begin failures++; $display("FAIL reset_wc got=%0d exp=0", word_count); end
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rden got=%b exp=0", fifo_rd_en); end
        rd_rst = 1'b0;
        clear_mon();
    endtask

    task automatic test_basic();
        logic ok;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) fq.push_back(8'(3 * k));
        wait_words(1, 40, ok);
        cycle(); cycle();
        checks++; if (!ok) begin failures++; $display("FAIL basic_wait got=%0d words exp=1", got_d.size()); end
        checks++; if (got_d[0] !== 32'h09060300) begin failures++; $display("FAIL basic_data got=%h exp=09060300", got_d[0]); end
        checks++; if (got_k[0] !== 4'hF) begin failures++; $display("FAIL basic_keep got=%h exp=f", got_k[0]); end
        checks++; if (word_count !== 16'd1) begin failures++; $display("FAIL basic_wc got=%0d exp=1", word_count); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL basic_pop_empty got=%0d exp=0", viol); end
    endtask

    task automatic test_backpressure();
        logic ok;
        logic [31:0] exp;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) fq.push_back(8'(3 * k));
        repeat (30) cycle();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'h09060300) begin failures++; $display("FAIL bp_hold got=%h exp=09060300", out_data); end
        checks++; if (fq.size() != 4) begin failures++; $display("FAIL bp_fifo_left got=%0d exp=4", fq.size()); end
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL bp_rden got=%b exp=0", fifo_rd_en); end
        out_ready = 1'b1;
        wait_words(3, 60, ok);
        cycle();
        checks++; if (!ok) begin failures++; $display("FAIL bp_wait got=%0d words exp=3", got_d.size()); end
        for (int w = 0; w < 3; w++) begin
            exp = pack4(8'(12 * w), 8'(12 * w + 3), 8'(12 * w + 6), 8'(12 * w + 9));
            checks++; if (got_d[w] !== exp) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", w, got_d[w], exp); end
        end
        checks++; if (hs_cyc[1] - hs_cyc[0] != 1) begin failures++; $display("FAIL bp_no_bubble got=%0d exp=1", hs_cyc[1] - hs_cyc[0]); end
        checks++; if (word_count !== 16'd3) begin failures++; $display("FAIL bp_wc got=%0d exp=3", word_count); end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
    endtask

    task automatic test_throughput();
        logic ok;
        logic [7:0] b[16];
        logic [31:0] exp;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            b[k] = 8'($urandom);
            fq.push_back(b[k]);
        end
        wait_words(4, 80, ok);
        checks++; if (!ok) begin failures++; $display("FAIL tp_wait got=%0d words exp=4", got_d.size()); end
        for (int w = 0; w < 4; w++) begin
            exp = pack4(b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]);
            checks++; if (got_d[w] !== exp) begin failures++; $display("FAIL tp_word%0d got=%h exp=%h", w, got_d[w], exp); end
        end
        for (int w = 1; w < 4; w++) begin
            checks++;
            if (hs_cyc[w] - hs_cyc[w-1] != int'(PACK) + 2) begin
                failures++; $display("FAIL tp_spacing%0d got=%0d exp=%0d", w, hs_cyc[w] - hs_cyc[w-1], PACK + 2);
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        out_ready = 1'b0;
        fq.push_back(8'hAA);
        fq.push_back(8'hBB);
        while (!out_valid && n < int'(TO) + 20) begin
            cycle();
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL to_valid got=%b exp=1", out_valid); end
        checks++;
        if (n < int'(TO) + 2 || n > int'(TO) + 8) begin
            failures++; $display("FAIL to_latency got=%0d exp=%0d..%0d", n, TO + 2, TO + 8);
        end
        checks++; if (out_data !== 32'h0000BBAA) begin failures++; $display("FAIL to_data got=%h exp=0000bbaa", out_data); end
        checks++; if (out_keep !== 4'b0011) begin failures++; $display("FAIL to_keep got=%b exp=0011", out_keep); end
        out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_flush_inflight();
        logic ok;
        logic [7:0] b[7];
        int n = 0;
        int extra = 0;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) b[k] = 8'($urandom);
        fq.push_back(b[0]);
        fq.push_back(b[1]);
        repeat (6) cycle();
        for (int k = 2; k < 7; k++) fq.push_back(b[k]);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++; if (rd_seen !== 1'b1) begin failures++; $display("FAIL fl_third_pop got=%b exp=1", rd_seen); end
        do begin
            cycle();
            n++;
            if (!ov_seen && rd_seen) extra++;
        end while (!ov_seen && n < 20);
        checks++; if (extra != 0) begin failures++; $display("FAIL fl_no_pop got=%0d exp=0", extra); end
        wait_words(2, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fl_wait got=%0d words exp=2", got_d.size()); end
        checks++; if (got_k[0] !== 4'b0111) begin failures++; $display("FAIL fl_keep got=%b exp=0111", got_k[0]); end
        checks++;
        if (got_d[0] !== {8'h00, b[2], b[1], b[0]}) begin
            failures++; $display("FAIL fl_data got=%h exp=%h", got_d[0], {8'h00, b[2], b[1], b[0]});
        end
        checks++;
        if (got_d[1] !== pack4(b[3], b[4], b[5], b[6]) || got_k[1] !== 4'hF) begin
            failures++; $display("FAIL fl_resume got=%h/%h exp=%h/f", got_d[1], got_k[1], pack4(b[3], b[4], b[5], b[6]));
        end
        repeat (4) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (10) cycle();
        checks++; if (got_d.size() != 2 || out_valid !== 1'b0) begin
            failures++; $display("FAIL fl_idle_flush got=%0d words valid=%b exp=2 words valid=0", got_d.size(), out_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic ok;
        logic [7:0] f[4];
        int n = 0;
        do_reset();
        out_ready = 1'b0;
        repeat (4) fq.push_back(8'($urandom));
        while (!out_valid && n < 20) begin cycle(); n++; end
        fq.push_back(8'($urandom));
        fq.push_back(8'($urandom));
        repeat (6) cycle();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mr_pre_valid got=%b exp=1", out_valid); end
        for (int k = 0; k < 4; k++) begin
            f[k] = 8'($urandom);
            fq.push_back(f[k]);
        end
        rd_rst = 1'b1;
        cycle();
        checks++; if (rd_seen !== 1'b0) begin failures++; $display("FAIL mr_rden_in_reset got=%b exp=0", rd_seen); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mr_valid got=%b exp=0", out_valid); end
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL mr_rden got=%b exp=0", fifo_rd_en); end
        checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL mr_wc got=%0d exp=0", word_count); end
        rd_rst = 1'b0;
        clear_mon();
        out_ready = 1'b1;
        wait_words(1, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mr_wait got=%0d words exp=1", got_d.size()); end
        checks++;
        if (got_d[0] !== pack4(f[0], f[1], f[2], f[3]) || got_k[0] !== 4'hF) begin
            failures++; $display("FAIL mr_fresh got=%h/%h exp=%h/f", got_d[0], got_k[0], pack4(f[0], f[1], f[2], f[3]));
        end
    endtask

    task automatic test_random();
        logic [7:0] stream[$];
        logic [7:0] b;
        logic [31:0] exp;
        int pushed = 0;
        int gap = 0;
        int k = 0;
        int bad = 0;
        localparam int NB = 160;
        do_reset();
        while (pushed < NB) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0 || gap >= 8) begin
                b = 8'($urandom);
                fq.push_back(b);
                stream.push_back(b);
                pushed++;
                gap = 0;
            end else begin
                gap++;
            end
            cycle();
        end
        while (got_d.size() < NB / int'(PACK) && k < 400) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            k++;
        end
        out_ready = 1'b0;
        cycle();
        checks++;
        if (got_d.size() != NB / int'(PACK)) begin
            failures++; $display("FAIL rnd_count got=%0d exp=%0d", got_d.size(), NB / int'(PACK));
        end
        for (int w = 0; w < NB / int'(PACK); w++) begin
            exp = pack4(stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]);
            checks++;
            if (got_d[w] !== exp || got_k[w] !== 4'hF) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL rnd_word%0d got=%h/%h exp=%h/f", w, got_d[w], got_k[w], exp);
            end
        end
        checks++; if (word_count !== 16'(NB / int'(PACK))) begin failures++; $display("FAIL rnd_wc got=%0d exp=%0d", word_count, NB / int'(PACK)); end
        checks++; if (word_count !== exp_wc) begin failures++; $display("FAIL rnd_wc_hs got=%0d exp=%0d", word_count, exp_wc); end
        checks++; if (viol != 0) begin failures++; $display("FAIL rnd_pop_empty got=%0d exp=0", viol); end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL rnd_stable got=%0d exp=0", stall_err); end
    endtask

    initial begin
        rd_rst     = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        flush      = 1'b0;
        out_ready  = 1'b0;
        exp_wc     = 16'd0;
        @(negedge rd_clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_throughput();
        test_timeout();
        test_flush_inflight();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d limit reached", cyc);
        $fatal(1);
    end

endmodule
